// File: rtl/ex_branch_unit.sv
// Execute-stage branch resolution unit: resolves JAL/JALR/BRANCH/MISC-MEM,
// queues writeback results in a small FIFO, raises a one-cycle fetch redirect
// on mispredict and counts resolved control transfers.
//
//   state | meaning
//   RUN   | transfers are resolved, queued, counted and may redirect fetch
//   DRAIN | mispredict seen; transfers are accepted and dropped until flush_i
module ex_branch_unit #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic             in_we,
    input  logic             in_rvc,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic [31:0]      out_wdata,
    output logic             out_taken,
    output logic             out_mispred,
    output logic             redirect_o,
    output logic [31:0]      redirect_addr_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   FULL_C  = {1'b1, {PTR_W{1'b0}}};
    localparam logic [CNT_W-1:0] PERF_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;

    typedef enum logic {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        logic             we;
        logic [31:0]      wdata;
        logic             taken;
        logic             mispred;
    } entry_t;

    state_t state_q, state_d;
    entry_t mem [DEPTH];
    entry_t res_entry, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic is_jal, is_jalr, is_br, is_misc, is_ctrl, br_cond;
    logic [31:0] seq_pc, pc_imm, res_target, res_actual;
    logic res_taken, res_mispred;
    logic push, pop;

    // Resolve the offered instruction: direction, target, writeback, mispredict.
    always_comb begin
        is_jal  = (in_opcode == OP_JAL);
        is_jalr = (in_opcode == OP_JALR);
        is_br   = (in_opcode == OP_BRANCH);
        is_misc = (in_opcode == OP_MISC);
        is_ctrl = is_jal | is_jalr | is_br | is_misc;
        seq_pc  = in_pc + (in_rvc ? 32'd2 : 32'd4);
        pc_imm  = in_pc + in_imm;
        br_cond = 1'b0;
        case (in_funct3)
            3'b000:  br_cond = (in_rs1 == in_rs2);
            3'b001:  br_cond = (in_rs1 != in_rs2);
            3'b100:  br_cond = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  br_cond = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  br_cond = (in_rs1 <  in_rs2);
            3'b111:  br_cond = (in_rs1 >= in_rs2);
            default: br_cond = 1'b0;
        endcase
        res_taken  = is_jal | is_jalr | is_misc | (is_br & br_cond);
        res_target = seq_pc;
        if (is_jal || is_br) res_target = pc_imm;
        if (is_jalr)         res_target = (in_rs1 + in_imm) & ~32'd1;
        res_actual  = res_taken ? res_target : seq_pc;
        // Non-control ops never redirect, so they are never flagged.
        res_mispred = is_misc | (is_ctrl & ((res_taken != in_pred_taken) |
                      (res_taken & (res_target != in_pred_target))));
        res_entry.tag     = in_tag;
        res_entry.rd      = in_rd;
        res_entry.we      = (is_jal | is_jalr) & in_we & (in_rd != 5'd0);
        res_entry.wdata   = (is_jal | is_jalr) ? seq_pc : 32'd0;
        res_entry.taken   = res_taken;
        res_entry.mispred = res_mispred;
    end

    assign in_ready  = !rst && ((count != FULL_C) || (state_q == DRAIN));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush_i && (state_q == RUN);
    assign pop       = out_valid && out_ready && !flush_i;

    assign head        = mem[rd_ptr];
    assign out_tag     = out_valid ? head.tag     : '0;
    assign out_rd      = out_valid ? head.rd      : 5'd0;
    assign out_we      = out_valid ? head.we      : 1'b0;
    assign out_wdata   = out_valid ? head.wdata   : 32'd0;
    assign out_taken   = out_valid ? head.taken   : 1'b0;
    assign out_mispred = out_valid ? head.mispred : 1'b0;

    // Next-state: flush always returns to RUN, a queued mispredict enters DRAIN.
    always_comb begin
        state_d = state_q;
        if (flush_i)                   state_d = RUN;
        else if (push && res_mispred)  state_d = DRAIN;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Result storage; only written on a push, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res_entry;
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    // One-cycle redirect after a queued mispredict; the address is held after.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_o      <= 1'b0;
            redirect_addr_o <= 32'd0;
        end else begin
            redirect_o <= push && res_mispred;
            if (push && res_mispred) redirect_addr_o <= res_actual;
        end
    end

    // Performance counters survive flush and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_o  <= '0;
            mis_cnt_o <= '0;
        end else if (push && is_ctrl) begin
            br_cnt_o <= br_cnt_o + PERF_ONE;
            if (res_mispred) mis_cnt_o <= mis_cnt_o + PERF_ONE;
        end
    end

endmodule

// File: tb/tb_ex_branch_unit.sv
// Directed bench for ex_branch_unit: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_ex_branch_unit;

    localparam int TAG_W = 6;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BR  = 7'b1100011, OP_MISC = 7'b0001111,
                           OP_SYS = 7'b1110011;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
    logic [6:0] in_opcode = '0;
    logic [2:0] in_funct3 = '0;
    logic [4:0] in_rd = '0;
    logic in_we = 1'b0, in_rvc = 1'b0, in_pred_taken = 1'b0;
    logic [31:0] in_pred_target = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic out_valid, out_ready = 1'b0;
    logic [TAG_W-1:0] out_tag;
    logic [4:0] out_rd;
    logic out_we, out_taken, out_mispred;
    logic [31:0] out_wdata;
    logic redirect_o;
    logic [31:0] redirect_addr_o;
    logic flush_i = 1'b0;
    logic [31:0] br_cnt_o, mis_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_br = 0, exp_mis = 0;

    ex_branch_unit #(.DEPTH(4), .TAG_W(TAG_W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd), .in_we(in_we),
        .in_rvc(in_rvc), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_rd(out_rd), .out_we(out_we), .out_wdata(out_wdata),
        .out_taken(out_taken), .out_mispred(out_mispred), .redirect_o(redirect_o),
        .redirect_addr_o(redirect_addr_o), .flush_i(flush_i),
        .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic rvc, input logic pt, input logic [31:0] ptgt,
                         input logic [4:0] rd, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_pc = pc; in_imm = imm;
        in_rs1 = rs1; in_rs2 = rs2; in_rvc = rvc; in_pred_taken = pt;
        in_pred_target = ptgt; in_rd = rd; in_we = 1'b1; in_tag = tag;
    endtask

    task automatic idle_drain();
        in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_wdata !== 32'd0 || out_tag !== '0) begin errors++; $display("FAIL rst_out_fields got %h/%h exp 0/0", out_wdata, out_tag); end
        checks++; if (redirect_o !== 1'b0 || redirect_addr_o !== 32'd0) begin errors++; $display("FAIL rst_redirect got %b/%h exp 0/0", redirect_o, redirect_addr_o); end
        checks++; if (br_cnt_o !== 32'd0 || mis_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", br_cnt_o, mis_cnt_o); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_jal();
        drive(OP_JAL, 3'b000, 32'h100, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'h120, 5'd1, 6'd1);
        tick(); in_valid = 1'b0; exp_br++;
        checks++; if (out_valid !== 1'b1 || out_tag !== 6'd1) begin errors++; $display("FAIL jal_valid got %b/%0d exp 1/1", out_valid, out_tag); end
        checks++; if (out_wdata !== 32'h104 || out_we !== 1'b1) begin errors++; $display("FAIL jal_wb got %h/%b exp 104/1", out_wdata, out_we); end
        checks++; if (out_taken !== 1'b1 || out_mispred !== 1'b0 || out_rd !== 5'd1) begin errors++; $display("FAIL jal_flags got t%b m%b rd%0d exp t1 m0 rd1", out_taken, out_mispred, out_rd); end
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL jal_redirect got %b exp 0", redirect_o); end
        checks++; if (br_cnt_o !== exp_br || mis_cnt_o !== exp_mis) begin errors++; $display("FAIL jal_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mis_cnt_o, exp_br, exp_mis); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_pop got %b exp 0", out_valid); end
    endtask

    task automatic test_blt_mispredict();
        drive(OP_BR, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 5'd0, 6'd2);
        tick(); exp_br++; exp_mis++;
        checks++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h240) begin errors++; $display("FAIL blt_redirect got %b/%h exp 1/240", redirect_o, redirect_addr_o); end
        checks++; if (out_taken !== 1'b1 || out_mispred !== 1'b1 || out_we !== 1'b0) begin errors++; $display("FAIL blt_flags got t%b m%b we%b exp t1 m1 we0", out_taken, out_mispred, out_we); end
        checks++; if (mis_cnt_o !== exp_mis || br_cnt_o !== exp_br) begin errors++; $display("FAIL blt_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mis_cnt_o, exp_br, exp_mis); end
        // DRAIN: this JAL is accepted but dropped
        drive(OP_JAL, 3'b000, 32'h800, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd3, 6'd3);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL redirect_pulse_len got %b exp 0", redirect_o); end
        checks++; if (br_cnt_o !== exp_br || mis_cnt_o !== exp_mis) begin errors++; $display("FAIL drain_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mis_cnt_o, exp_br, exp_mis); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_dropped got %b exp 0", out_valid); end
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        drive(OP_JAL, 3'b000, 32'h900, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'h910, 5'd4, 6'd4);
        tick(); in_valid = 1'b0; exp_br++;
        checks++; if (out_valid !== 1'b1 || out_tag !== 6'd4 || br_cnt_o !== exp_br) begin errors++; $display("FAIL after_flush_run got v%b tag%0d cnt%0d exp v1 tag4 cnt%0d", out_valid, out_tag, br_cnt_o, exp_br); end
        idle_drain();
    endtask

    task automatic test_jalr_rvc();
        drive(OP_JALR, 3'b000, 32'h300, 32'h0, 32'h1001, 32'h0, 1'b1, 1'b1, 32'h1000, 5'd0, 6'd5);
        tick(); in_valid = 1'b0; exp_br++;
        checks++; if (out_we !== 1'b0 || out_wdata !== 32'h302) begin errors++; $display("FAIL jalr_wb got %b/%h exp 0/302", out_we, out_wdata); end
        checks++; if (out_mispred !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("FAIL jalr_target got m%b r%b exp m0 r0", out_mispred, redirect_o); end
        idle_drain();
        drive(OP_JALR, 3'b000, 32'h300, 32'h0, 32'h1001, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0, 6'd6);
        tick(); in_valid = 1'b0; exp_br++; exp_mis++;
        checks++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h1000) begin errors++; $display("FAIL jalr_redirect got %b/%h exp 1/1000", redirect_o, redirect_addr_o); end
        idle_drain();
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            drive(OP_JAL, 3'b000, 32'h400 + 32'(i * 16), 32'h8, 32'h0, 32'h0, 1'b0, 1'b1,
                  32'h408 + 32'(i * 16), 5'd2, 6'(10 + i));
            tick(); exp_br++;
        end
        drive(OP_JAL, 3'b000, 32'h440, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 32'h448, 5'd2, 6'd14);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_tag !== 6'd10 || out_wdata !== 32'h404 || in_ready !== 1'b0) begin errors++; $display("FAIL full_stall got tag%0d wd%h rdy%b exp tag10 wd404 rdy0", out_tag, out_wdata, in_ready); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_tag !== 6'd11) begin errors++; $display("FAIL full_pop got rdy%b tag%0d exp rdy1 tag11", in_ready, out_tag); end
        tick(); in_valid = 1'b0; exp_br++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_again got %b exp 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_tag !== 6'(10 + i) || out_wdata !== 32'h404 + 32'(i * 16)) begin errors++; $display("FAIL fifo_order_%0d got v%b tag%0d wd%h exp v1 tag%0d wd%h", i, out_valid, out_tag, out_wdata, 10 + i, 32'h404 + 32'(i * 16)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || br_cnt_o !== exp_br) begin errors++; $display("FAIL fifo_empty got v%b cnt%0d exp v0 cnt%0d", out_valid, br_cnt_o, exp_br); end
    endtask

    task automatic test_flush_mispredict();
        for (int i = 0; i < 2; i++) begin
            drive(OP_JAL, 3'b000, 32'h600, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 32'h608, 5'd7, 6'(20 + i));
            tick(); exp_br++;
        end
        drive(OP_BR, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 5'd0, 6'd22);
        flush_i = 1'b1; tick(); flush_i = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got v%b r%b exp v0 r0", out_valid, redirect_o); end
        checks++; if (br_cnt_o !== exp_br || mis_cnt_o !== exp_mis) begin errors++; $display("FAIL flush_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mis_cnt_o, exp_br, exp_mis); end
        tick();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL flush_late_redirect got %b exp 0", redirect_o); end
        drive(OP_JAL, 3'b000, 32'h700, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 32'h708, 5'd7, 6'd23);
        tick(); in_valid = 1'b0; exp_br++;
        checks++; if (out_valid !== 1'b1 || out_tag !== 6'd23) begin errors++; $display("FAIL flush_run got v%b tag%0d exp v1 tag23", out_valid, out_tag); end
        idle_drain();
    endtask

    task automatic test_bgeu();
        drive(OP_BR, 3'b111, 32'h500, 32'h100, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h600, 5'd0, 6'd24);
        tick(); in_valid = 1'b0; exp_br++; exp_mis++;
        checks++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h504) begin errors++; $display("FAIL bgeu_redirect got %b/%h exp 1/504", redirect_o, redirect_addr_o); end
        checks++; if (out_taken !== 1'b0 || out_mispred !== 1'b1 || out_wdata !== 32'd0) begin errors++; $display("FAIL bgeu_flags got t%b m%b wd%h exp t0 m1 wd0", out_taken, out_mispred, out_wdata); end
        idle_drain();
    endtask

    task automatic test_misc_and_system();
        drive(OP_MISC, 3'b000, 32'h700, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h704, 5'd0, 6'd25);
        tick(); in_valid = 1'b0; exp_br++; exp_mis++;
        checks++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h704 || out_mispred !== 1'b1) begin errors++; $display("FAIL misc_mispred got r%b a%h m%b exp r1 a704 m1", redirect_o, redirect_addr_o, out_mispred); end
        checks++; if (mis_cnt_o !== exp_mis || br_cnt_o !== exp_br) begin errors++; $display("FAIL misc_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mis_cnt_o, exp_br, exp_mis); end
        idle_drain();
        drive(OP_SYS, 3'b000, 32'h710, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 6'd26);
        tick(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_we !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("FAIL system_op got v%b t%b we%b r%b exp v1 t0 we0 r0", out_valid, out_taken, out_we, redirect_o); end
        checks++; if (br_cnt_o !== exp_br) begin errors++; $display("FAIL system_count got %0d exp %0d", br_cnt_o, exp_br); end
        idle_drain();
    endtask

    task automatic test_reset_mid();
        drive(OP_JAL, 3'b000, 32'h100, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'h120, 5'd1, 6'd30);
        tick();
        drive(OP_BR, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 5'd0, 6'd31);
        rst = 1'b1; flush_i = 1'b1;
        tick(); in_valid = 1'b0; flush_i = 1'b0; exp_br = 0; exp_mis = 0;
        checks++; if (out_valid !== 1'b0 || redirect_o !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got v%b r%b rdy%b exp v0 r0 rdy0", out_valid, redirect_o, in_ready); end
        checks++; if (br_cnt_o !== 32'd0 || mis_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_rst_counters got %0d/%0d exp 0/0", br_cnt_o, mis_cnt_o); end
        rst = 1'b0; tick();
        checks++; if (redirect_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_after got r%b rdy%b exp r0 rdy1", redirect_o, in_ready); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_blt_mispredict();
        test_jalr_rvc();
        test_fifo_full();
        test_flush_mispredict();
        test_bgeu();
        test_misc_and_system();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_branch_unit.md
EX_BRANCH_UNIT -- requirements
Module: ex_branch_unit

Interface
REQ-001 Parameter DEPTH, default 4: result FIFO entries; power of 2, minimum 2.
REQ-002 Parameter TAG_W, default 6: width of the instruction tag carried to writeback.
REQ-003 Parameter CNT_W, default 32: width of the performance counters.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with the ports below.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 in_valid / in_ready  in / out  1 / 1  issue handshake; a transfer occurs when both are high at a rising edge.
REQ-008 in_pc, in_imm, in_rs1, in_rs2  in  32 each  instruction PC, sign-extended immediate, operand values.
REQ-009 in_opcode  in  7; in_funct3  in  3; in_rd  in  5; in_we  in  1  decoded fields.
REQ-010 in_rvc  in  1  1 means a 16-bit compressed instruction, so ilen=2; otherwise ilen=4.
REQ-011 in_pred_taken  in  1; in_pred_target  in  32  frontend prediction.
REQ-012 in_tag  in  TAG_W  instruction tag.
REQ-013 out_valid / out_ready  out / in  1 / 1  writeback handshake on the FIFO head.
REQ-014 out_tag  TAG_W; out_rd  5; out_we  1; out_wdata  32; out_taken  1; out_mispred  1  head entry fields.
REQ-015 redirect_o  out  1; redirect_addr_o  out  32  one-cycle fetch redirect pulse and its target.
REQ-016 flush_i  in  1  pipeline flush from commit.
REQ-017 br_cnt_o, mis_cnt_o  out  CNT_W  resolved-control and mispredict counters.

Function
REQ-018 Opcodes and taken/target rules:
- JAL 1101111: always taken; target = pc+imm.
- JALR 1100111: always taken; target = (rs1+imm) & ~1.
- BRANCH 1100011: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned); target = pc+imm if taken.
- MISC-MEM 0001111: taken to pc+ilen.
- SYSTEM 1110011 and any other opcode: not taken, no write, no redirect.
- All adds are mod 2^32.
REQ-019 Writeback data: JAL/JALR write wdata = pc+ilen with we = in_we & (rd!=0); all other ops write we=0, wdata=0.
REQ-020 Next PC: actual = taken ? target : pc+ilen.
- Mispredict = (taken != pred_taken) | (taken & target != pred_target).
- MISC-MEM is always mispredicted.
REQ-021 in_ready SHALL be high when FIFO count < DEPTH or state is DRAIN, and low during rst.
REQ-022 On an accepted transfer in state RUN, the resolved entry SHALL be written to the FIFO tail at that edge, so out_valid can rise the next cycle (latency 1).
REQ-023 On a mispredicted transfer in RUN: at the next cycle, redirect_o=1 for exactly one cycle with redirect_addr_o = actual next PC, and the state moves to DRAIN.
REQ-024 State DRAIN: accepted transfers are discarded (not written, no redirect, no count); the state stays DRAIN until flush_i, then goes to RUN.
REQ-025 flush_i SHALL, at that edge:
- empty the FIFO;
- suppress any redirect pending for the next cycle;
- drop any same-cycle transfer;
- set the state to RUN.
flush_i has priority over acceptance and pop.
REQ-026 Simultaneous push and pop with the FIFO full is not allowed; in_ready stays low when full. Pop with the FIFO empty does nothing.
REQ-027 Pointers wrap modulo DEPTH, and entries are read in FIFO order.
REQ-028 Counters:
- br_cnt_o increments on every accepted transfer in RUN whose opcode is JAL, JALR, BRANCH or MISC-MEM.
- mis_cnt_o increments on every such transfer that is mispredicted.
- Both wrap at 2^CNT_W and are not cleared by flush_i.
REQ-029 Output head fields SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-030 At rst:
- FIFO empty, out_valid=0, all out_* fields 0;
- redirect_o=0, redirect_addr_o=0;
- state=RUN;
- both counters 0;
- in_ready=0 during the rst cycle.
REQ-031 Reset applied mid-operation discards all entries and any pending redirect; rst has priority over flush_i.

Verification
REQ-032 JAL pc=0x100, imm=0x20, rd=1, rvc=0, pred taken to 0x120 -> next cycle out_wdata=0x104, out_we=1, out_mispred=0, redirect_o=0, br_cnt=1.
REQ-033 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred not taken -> taken=1, redirect to 0x240, mis_cnt=1, state DRAIN; next transfer is dropped until flush_i.
REQ-034 Compressed JALR (rvc=1) pc=0x300, rs1=0x1001, imm=0, rd=0 -> target 0x1000, we=0, wdata=0x302.
REQ-035 DEPTH=4, out_ready=0, 5 non-mispredicted transfers offered -> 4 accepted, in_ready low; one pop -> 5th accepted; outputs emerge in order with tags intact.
REQ-036 flush_i in the same cycle as a mispredicted transfer with FIFO holding 2 entries -> FIFO empty, no redirect pulse, counters unchanged.
REQ-037 BGEU rs1=1, rs2=0xFFFFFFFF, pred taken -> not taken, redirect to pc+4, out_taken=0, out_mispred=1.
